lsu_arbiter: RTL and testbench
==============================

Name: lsu_arbiter

Overview:
- Two-requester arbiter in front of the load/store unit (lsu). It shares the single LSU port (data memory plus memory-mapped LEDs, HEX, LCD and switches) between the core's memory stage (M0) and a DMA/debug loader (M1).
- Round-robin fairness, with optional bounded lock for back-to-back bursts.
- Read data is registered and returned one cycle after grant with a valid strobe.
- Sits between the core/DMA and the lsu instance; the lsu itself is unchanged.

Parameters:
- LOCK_MAX, 4, maximum consecutive grants a locking master may hold (1..15).
- ADDR_W, 32, address width passed through to the LSU.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_m0_req  in  1  core request valid
- i_m0_wren  in  1  core store (1) / load (0)
- i_m0_lock  in  1  core requests to keep ownership after this access
- i_m0_addr  in  ADDR_W  core address
- i_m0_wdata  in  32  core store data
- i_m0_funct3  in  3  core access size/sign (RV32I load/store funct3)
- o_m0_gnt  out  1  core request accepted this cycle
- o_m0_rvalid  out  1  core read data valid
- o_m0_rdata  out  32  core read data
- i_m1_req, i_m1_wren, i_m1_lock, i_m1_addr, i_m1_wdata, i_m1_funct3  in  1/1/1/ADDR_W/32/3  same meaning for M1
- o_m1_gnt, o_m1_rvalid, o_m1_rdata  out  1/1/32  same meaning for M1
- o_lsu_addr  out  ADDR_W  to lsu i_lsu_addr
- o_lsu_st_data  out  32  to lsu i_st_data
- o_lsu_wren  out  1  to lsu i_lsu_wren
- o_lsu_funct3  out  3  to lsu i_funct3
- i_lsu_ld_data  in  32  from lsu o_ld_data (combinational)

Interface (already decided): reset i_reset, asynchronous, active-low; clock i_clk.

Behaviour:
- State machine, states ARB_IDLE, ARB_OWN0, ARB_OWN1. Registers:
  - state
  - rr_last (last granted master)
  - lock_cnt (4 bits)
  - rvalid0, rvalid1, rdata0, rdata1
- Reset (i_reset=0, async): state=ARB_IDLE, rr_last=1 so M0 wins the first tie, lock_cnt=0, both rvalid=0, both rdata=0. Reset mid-access drops the access; no rvalid follows.
- Grant is combinational within the cycle:
  - ARB_IDLE: one req set, grant it. Both set, grant the master != rr_last.
  - ARB_OWNx: grant x if i_mx_req=1. Otherwise fall back to the ARB_IDLE rule for this cycle.
- At most one o_mx_gnt high per cycle.
- Slave mux: granted master's addr, wdata, wren, funct3 drive o_lsu_*. With no grant: o_lsu_wren=0, o_lsu_addr=0, o_lsu_st_data=0, o_lsu_funct3=3'b010.
- Store: write happens at the grant edge inside the lsu. No response strobe; o_mx_gnt is the only acknowledgement.
- Load:
  - At the grant edge, rdata_x <= i_lsu_ld_data and rvalid_x <= 1.
  - Latency is exactly 1 cycle after gnt. rvalid is a 1-cycle pulse per load grant; back-to-back load grants give back-to-back pulses.
  - rdata_x holds its value until the next load for that master.
- Stores never assert rvalid.
- Transitions on each grant edge to master x:
  - rr_last <= x.
  - If i_mx_lock=1 and lock_cnt+1 < LOCK_MAX: state <= ARB_OWNx, lock_cnt <= lock_cnt+1.
  - Otherwise: state <= ARB_IDLE, lock_cnt <= 0.
  - Cycle with no grant: state <= ARB_IDLE, lock_cnt <= 0.
- Lock bound: a master holding lock with continuous req receives exactly LOCK_MAX consecutive grants. The next tie then goes to the other master (rr_last rule).
- Lock with req dropped: ownership is released immediately; no idle cycle is inserted.
- Masters hold req and payload stable until gnt. Changing them before gnt is allowed and takes effect as the new request.
- Address decode and byte masking remain inside the lsu. The arbiter is address-agnostic.

Decomposition:
- Package lsu_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_OWN0, ARB_OWN1}
  - constant ARB_IDLE_FUNCT3 = 3'b010
  - constant ARB_N_MASTERS = 2
- One sub-module, lsu_arb_rr_pick: a 2-way round-robin picker. Inputs req[1:0], last. Output one-hot grant[1:0]. Purely combinational, reused by the idle rule.

Test Plan:
- M0 only, SW addr 0x0000_0010 data 0xDEAD_BEEF, then LW same addr:
  - o_m0_gnt high both cycles.
  - o_m0_rvalid pulses the cycle after the LW grant with o_m0_rdata=0xDEAD_BEEF.
  - M1 outputs stay 0.
- Both req every cycle, no lock: grants alternate M0, M1, M0, M1 starting with M0 after reset; never both gnt in one cycle.
- M1 lock=1 continuous req, M0 req continuous, LOCK_MAX=4: M1 gets 4 consecutive grants, then M0 is granted on the 5th cycle.
- M0 load from 0x1000_0000 (LEDR previously written 0x0000_00A5 by M1 SW): o_m0_rdata=0x0000_00A5 one cycle after grant; o_m1_rvalid remains 0.
- M0 locked, drops req mid-lock while M1 req=1: M1 granted in that same cycle; state returns to ARB_IDLE/ARB_OWN1 per M1 lock.
- Assert i_reset=0 during the cycle after an M1 load grant: o_m1_rvalid=0 immediately, and all outputs return to reset values. After release, the first tie goes to M0.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-master LSU arbiter.
// Imported by the picker and the arbiter top.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1
    } arb_state_t;

    localparam logic [2:0] ARB_IDLE_FUNCT3 = 3'b010;
    localparam int         ARB_N_MASTERS   = 2;

endpackage

// File: rtl/lsu_arb_rr_pick.sv
// Two-way round-robin picker: on a tie the master that was not
// granted last wins. Purely combinational, one-hot or zero output.
module lsu_arb_rr_pick
    import lsu_arb_pkg::*;
(
    input  logic [ARB_N_MASTERS-1:0] req_i,
    input  logic                     last_i,
    output logic [ARB_N_MASTERS-1:0] grant_o
);

    assign grant_o[0] = req_i[0] & (~req_i[1] | last_i);
    assign grant_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LSU port between the core memory stage (M0) and a DMA
// loader (M1): round-robin with bounded lock, registered read return.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int LOCK_MAX = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_wren,
    input  logic              i_m0_lock,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [31:0]       i_m0_wdata,
    input  logic [2:0]        i_m0_funct3,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [31:0]       o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_wren,
    input  logic              i_m1_lock,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [31:0]       i_m1_wdata,
    input  logic [2:0]        i_m1_funct3,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [31:0]       o_m1_rdata,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [31:0]       o_lsu_st_data,
    output logic              o_lsu_wren,
    output logic [2:0]        o_lsu_funct3,
    input  logic [31:0]       i_lsu_ld_data
);

    localparam logic [4:0] LOCK_MAX_W = 5'(LOCK_MAX);

    arb_state_t  state_q, state_d;
    logic        rr_last_q, rr_last_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic [1:0]  req;
    logic [1:0]  pick;
    logic [1:0]  gnt;
    logic        sel_lock;
    logic [4:0]  cnt_inc;

    assign req = {i_m1_req, i_m0_req};

    lsu_arb_rr_pick u_pick (
        .req_i   (req),
        .last_i  (rr_last_q),
        .grant_o (pick)
    );

    // An owner keeps the port only while it still requests.
    always_comb begin
        gnt = pick;
        case (state_q)
            ARB_OWN0: if (i_m0_req) gnt = 2'b01;
            ARB_OWN1: if (i_m1_req) gnt = 2'b10;
            default:  gnt = pick;
        endcase
    end

    always_comb begin
        o_lsu_addr    = '0;
        o_lsu_st_data = '0;
        o_lsu_wren    = 1'b0;
        o_lsu_funct3  = ARB_IDLE_FUNCT3;
        sel_lock      = 1'b0;
        if (gnt[0]) begin
            o_lsu_addr    = i_m0_addr;
            o_lsu_st_data = i_m0_wdata;
            o_lsu_wren    = i_m0_wren;
            o_lsu_funct3  = i_m0_funct3;
            sel_lock      = i_m0_lock;
        end else if (gnt[1]) begin
            o_lsu_addr    = i_m1_addr;
            o_lsu_st_data = i_m1_wdata;
            o_lsu_wren    = i_m1_wren;
            o_lsu_funct3  = i_m1_funct3;
            sel_lock      = i_m1_lock;
        end
    end

    assign cnt_inc = {1'b0, lock_cnt_q} + 5'd1;

    always_comb begin
        state_d    = ARB_IDLE;
        lock_cnt_d = '0;
        rr_last_d  = rr_last_q;
        if (|gnt) begin
            rr_last_d = gnt[1];
            if (sel_lock && (cnt_inc < LOCK_MAX_W)) begin
                state_d    = gnt[1] ? ARB_OWN1 : ARB_OWN0;
                lock_cnt_d = cnt_inc[3:0];
            end
        end
    end

    assign rvalid0_d = gnt[0] & ~i_m0_wren;
    assign rvalid1_d = gnt[1] & ~i_m1_wren;
    assign rdata0_d  = rvalid0_d ? i_lsu_ld_data : rdata0_q;
    assign rdata1_d  = rvalid1_d ? i_lsu_ld_data : rdata1_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ARB_IDLE;
            rr_last_q  <= 1'b1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign o_m0_gnt    = gnt[0];
    assign o_m1_gnt    = gnt[1];
    assign o_m0_rvalid = rvalid0_q;
    assign o_m1_rvalid = rvalid1_q;
    assign o_m0_rdata  = rdata0_q;
    assign o_m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed sequences, a grant table and a
// randomized run against a behavioural model with an LSU memory stand-in.
module tb_lsu_arbiter;

    localparam int LOCK_MAX = 4;
    localparam int ADDR_W   = 32;

    logic              i_clk;
    logic              i_reset;
    logic              i_m0_req, i_m0_wren, i_m0_lock;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [31:0]       i_m0_wdata;
    logic [2:0]        i_m0_funct3;
    logic              o_m0_gnt, o_m0_rvalid;
    logic [31:0]       o_m0_rdata;
    logic              i_m1_req, i_m1_wren, i_m1_lock;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [31:0]       i_m1_wdata;
    logic [2:0]        i_m1_funct3;
    logic              o_m1_gnt, o_m1_rvalid;
    logic [31:0]       o_m1_rdata;
    logic [ADDR_W-1:0] o_lsu_addr;
    logic [31:0]       o_lsu_st_data;
    logic              o_lsu_wren;
    logic [2:0]        o_lsu_funct3;
    logic [31:0]       i_lsu_ld_data;

    lsu_arbiter #(.LOCK_MAX(LOCK_MAX), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_req(i_m0_req), .i_m0_wren(i_m0_wren), .i_m0_lock(i_m0_lock),
        .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .i_m0_funct3(i_m0_funct3),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid),
        .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_wren(i_m1_wren), .i_m1_lock(i_m1_lock),
        .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .i_m1_funct3(i_m1_funct3),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid),
        .o_m1_rdata(o_m1_rdata),
        .o_lsu_addr(o_lsu_addr), .o_lsu_st_data(o_lsu_st_data),
        .o_lsu_wren(o_lsu_wren), .o_lsu_funct3(o_lsu_funct3),
        .i_lsu_ld_data(i_lsu_ld_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errs   = 0;
    int checks = 0;

    logic [31:0] mem [logic [31:0]];

    int          own;
    int          last;
    int          cnt;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          s_g0, s_g1;

    typedef struct {
        bit r0, l0, r1, l1;
        bit g0, g1;
    } vec_t;
    vec_t tv [17];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        own = -1; last = 1; cnt = 0;
        exp_rv[0] = 0; exp_rv[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    task automatic drv0(bit r, bit w, bit l, logic [31:0] a,
                        logic [31:0] d, logic [2:0] f);
        i_m0_req = r; i_m0_wren = w; i_m0_lock = l;
        i_m0_addr = a; i_m0_wdata = d; i_m0_funct3 = f;
    endtask

    task automatic drv1(bit r, bit w, bit l, logic [31:0] a,
                        logic [31:0] d, logic [2:0] f);
        i_m1_req = r; i_m1_wren = w; i_m1_lock = l;
        i_m1_addr = a; i_m1_wdata = d; i_m1_funct3 = f;
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_gnt0"}, o_m0_gnt, 0);
        chk({tag, "_gnt1"}, o_m1_gnt, 0);
        chk({tag, "_rv0"}, o_m0_rvalid, 0);
        chk({tag, "_rv1"}, o_m1_rvalid, 0);
        chk({tag, "_rd0"}, o_m0_rdata, 0);
        chk({tag, "_rd1"}, o_m1_rdata, 0);
        chk({tag, "_addr"}, o_lsu_addr, 0);
        chk({tag, "_wdat"}, o_lsu_st_data, 0);
        chk({tag, "_wren"}, o_lsu_wren, 0);
        chk({tag, "_f3"}, o_lsu_funct3, 3'b010);
    endtask

    // One bus cycle, entered and left at a falling edge with inputs driven.
    task automatic step();
        int          g;
        logic [31:0] a, d;
        logic [2:0]  f;
        bit          w, lk;
        #1;
        i_lsu_ld_data = mem_rd(o_lsu_addr);
        #1;
        if (own == 0 && i_m0_req) g = 0;
        else if (own == 1 && i_m1_req) g = 1;
        else if (i_m0_req && i_m1_req) g = 1 - last;
        else if (i_m0_req) g = 0;
        else if (i_m1_req) g = 1;
        else g = -1;
        s_g0 = o_m0_gnt;
        s_g1 = o_m1_gnt;
        a = '0; d = '0; f = 3'b010; w = 0; lk = 0;
        if (g == 0) begin
            a = i_m0_addr; d = i_m0_wdata; f = i_m0_funct3;
            w = i_m0_wren; lk = i_m0_lock;
        end else if (g == 1) begin
            a = i_m1_addr; d = i_m1_wdata; f = i_m1_funct3;
            w = i_m1_wren; lk = i_m1_lock;
        end
        chk("gnt0", o_m0_gnt, g == 0);
        chk("gnt1", o_m1_gnt, g == 1);
        chk("lsu_addr", o_lsu_addr, a);
        chk("lsu_wdata", o_lsu_st_data, d);
        chk("lsu_wren", o_lsu_wren, w);
        chk("lsu_funct3", o_lsu_funct3, f);
        @(posedge i_clk);
        exp_rv[0] = 0; exp_rv[1] = 0;
        if (g >= 0) begin
            last = g;
            if (lk && cnt + 1 < LOCK_MAX) begin
                own = g; cnt++;
            end else begin
                own = -1; cnt = 0;
            end
            if (w) mem[a] = d;
            else begin
                exp_rv[g] = 1;
                exp_rd[g] = mem_rd(a);
            end
        end else begin
            own = -1; cnt = 0;
        end
        #1;
        chk("rvalid0", o_m0_rvalid, exp_rv[0]);
        chk("rvalid1", o_m1_rvalid, exp_rv[1]);
        chk("rdata0", o_m0_rdata, exp_rd[0]);
        chk("rdata1", o_m1_rdata, exp_rd[1]);
        @(negedge i_clk);
    endtask

    task automatic do_reset(string tag);
        i_reset = 1'b0;
        drv0(0, 0, 0, '0, '0, 3'b000);
        drv1(0, 0, 0, '0, '0, 3'b000);
        model_reset();
        #1;
        chk_idle_outputs(tag);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    initial begin
        tv[0]  = '{1, 0, 1, 0, 1, 0};
        tv[1]  = '{1, 0, 1, 0, 0, 1};
        tv[2]  = '{1, 0, 1, 0, 1, 0};
        tv[3]  = '{1, 0, 1, 0, 0, 1};
        tv[4]  = '{1, 0, 0, 1, 1, 0};
        tv[5]  = '{1, 0, 1, 1, 0, 1};
        tv[6]  = '{1, 0, 1, 1, 0, 1};
        tv[7]  = '{1, 0, 1, 1, 0, 1};
        tv[8]  = '{1, 0, 1, 1, 0, 1};
        tv[9]  = '{1, 0, 1, 1, 1, 0};
        tv[10] = '{0, 0, 0, 0, 0, 0};
        tv[11] = '{1, 1, 1, 0, 0, 1};
        tv[12] = '{1, 1, 1, 0, 1, 0};
        tv[13] = '{1, 1, 1, 0, 1, 0};
        tv[14] = '{0, 1, 1, 1, 0, 1};
        tv[15] = '{1, 0, 1, 0, 0, 1};
        tv[16] = '{1, 0, 1, 0, 1, 0};

        i_lsu_ld_data = '0;
        @(negedge i_clk);
        do_reset("por");

        // Store then load on M0 alone
        drv0(1, 1, 0, 32'h10, 32'hDEAD_BEEF, 3'b010);
        step();
        chk("sw_gnt", s_g0, 1);
        drv0(1, 0, 0, 32'h10, 32'h0, 3'b010);
        step();
        chk("lw_gnt", s_g0, 1);
        drv0(0, 0, 0, '0, '0, 3'b000);
        chk("lw_rvalid", o_m0_rvalid, 1);
        chk("lw_rdata", o_m0_rdata, 32'hDEAD_BEEF);
        chk("lw_m1_rv", o_m1_rvalid, 0);
        chk("lw_m1_rd", o_m1_rdata, 0);

        // M1 writes LEDR, M0 reads it back
        drv1(1, 1, 0, 32'h1000_0000, 32'h0000_00A5, 3'b010);
        step();
        drv1(0, 0, 0, '0, '0, 3'b000);
        drv0(1, 0, 0, 32'h1000_0000, 32'h0, 3'b010);
        step();
        drv0(0, 0, 0, '0, '0, 3'b000);
        chk("ledr_rdata", o_m0_rdata, 32'h0000_00A5);
        chk("ledr_m1_rv", o_m1_rvalid, 0);

        // Reset while an M1 load response is pending
        drv1(1, 0, 0, 32'h20, 32'h0, 3'b010);
        step();
        chk("pre_rst_rv1", o_m1_rvalid, 1);
        do_reset("mid");

        for (int i = 0; i < 17; i++) begin
            drv0(tv[i].r0, 0, tv[i].l0, 32'h40 + 32'(4 * i),
                 32'h0, 3'b010);
            drv1(tv[i].r1, 0, tv[i].l1, 32'h80 + 32'(4 * i),
                 32'h0, 3'b100);
            step();
            chk($sformatf("tbl%0d_g0", i), s_g0, tv[i].g0);
            chk($sformatf("tbl%0d_g1", i), s_g1, tv[i].g1);
        end

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd");
            end else begin
                drv0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1,
                     32'(4 * $urandom_range(0, 15)), $urandom,
                     3'($urandom_range(0, 7)));
                drv1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1,
                     32'(4 * $urandom_range(0, 15)), $urandom,
                     3'($urandom_range(0, 7)));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
